note_player_poly: RTL

- Polyphonic successor to the single-voice note player; plays NUM_VOICES notes at once.
- Each voice has a beat-driven duration counter and a phase accumulator producing a square or sawtooth waveform.
- Voices are summed with saturation into one codec sample, delivered through the generate_next_sample / new_sample_ready handshake.
- Sits between the song sequencer, which loads notes per voice, and the codec interface.

---
 rtl/note_player_poly_if.sv | 33 +++
 rtl/note_player_poly.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/note_player_poly_if.sv
// Sequencer/codec-facing bundle of note_player_poly: note loads, play/beat controls, sample handshake.
interface note_player_poly_if #(
  parameter int NUM_VOICES = 2,
  parameter int DUR_W      = 6,
  parameter int PHASE_W    = 20,
  parameter int SAMPLE_W   = 16
);
  localparam int VSEL_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic                  play_enable;
  logic                  load_new_note;
  logic [VSEL_W-1:0]     voice_sel;
  logic [PHASE_W-1:0]    step_to_load;
  logic [DUR_W-1:0]      duration_to_load;
  logic                  wave_mode;
  logic                  beat;
  logic                  generate_next_sample;
  logic [NUM_VOICES-1:0] done_with_note;
  logic [SAMPLE_W-1:0]   sample_out;
  logic                  new_sample_ready;

  modport master (
    output play_enable, load_new_note, voice_sel, step_to_load, duration_to_load,
           wave_mode, beat, generate_next_sample,
    input  done_with_note, sample_out, new_sample_ready
  );

  modport slave (
    input  play_enable, load_new_note, voice_sel, step_to_load, duration_to_load,
           wave_mode, beat, generate_next_sample,
    output done_with_note, sample_out, new_sample_ready
  );
endinterface

// File: rtl/note_player_poly.sv
// Polyphonic note player: per-voice beat counters and square/saw oscillators, saturating mix; sample latency 2, no backpressure.
// Optional macro NOTE_PLAYER_RELEASE_EN adds a decaying RELEASE tail to each voice.
module note_player_poly #(
  parameter int NUM_VOICES = 2,
  parameter int DUR_W      = 6,
  parameter int PHASE_W    = 20,
  parameter int SAMPLE_W   = 16
) (
  input logic               clk,
  input logic               reset,
  note_player_poly_if.slave bus
);
  localparam int VSEL_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int SUM_W  = SAMPLE_W + 3;
  localparam logic [SAMPLE_W-1:0] SQ_POS  = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] SQ_NEG  = {1'b1, {(SAMPLE_W-2){1'b0}}, 1'b1};
  localparam logic [SAMPLE_W-1:0] SAT_MAX = SQ_POS;
  localparam logic [SAMPLE_W-1:0] SAT_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

`ifdef NOTE_PLAYER_RELEASE_EN
  typedef enum logic [1:0] {IDLE, PLAYING, RELEASE} voice_state_t;
`else
  typedef enum logic [1:0] {IDLE, PLAYING} voice_state_t;
`endif

  voice_state_t        state_q [NUM_VOICES];
  voice_state_t        state_d [NUM_VOICES];
  logic [DUR_W-1:0]    count_q [NUM_VOICES];
  logic [DUR_W-1:0]    count_d [NUM_VOICES];
  logic [PHASE_W-1:0]  phase_q [NUM_VOICES];
  logic [PHASE_W-1:0]  phase_d [NUM_VOICES];
  logic [PHASE_W-1:0]  step_q  [NUM_VOICES];
  logic [PHASE_W-1:0]  step_d  [NUM_VOICES];
`ifdef NOTE_PLAYER_RELEASE_EN
  logic [2:0]          rel_q   [NUM_VOICES];
  logic [2:0]          rel_d   [NUM_VOICES];
`endif

  logic [NUM_VOICES-1:0] load_hit;
  logic [NUM_VOICES-1:0] adv;
  logic [NUM_VOICES-1:0] done;
  logic                  beat_en;

  logic signed [SAMPLE_W-1:0] wave    [NUM_VOICES];
  logic signed [SAMPLE_W-1:0] s1_wave [NUM_VOICES];
  logic                       s1_vld;
  logic [SUM_W-1:0]           sum;
  logic [SAMPLE_W-1:0]        mix;
  logic [SAMPLE_W-1:0]        sample_q;
  logic                       ready_q;

  function automatic logic [SAMPLE_W-1:0] wave_of(input logic [PHASE_W-1:0] ph, input logic saw);
    logic [SAMPLE_W-1:0] top;
    top = ph[PHASE_W-1 -: SAMPLE_W];
    if (saw) return {~top[SAMPLE_W-1], top[SAMPLE_W-2:0]};
    return top[SAMPLE_W-1] ? SQ_NEG : SQ_POS;
  endfunction

  assign beat_en = bus.play_enable & bus.beat;

  // Out-of-range voice_sel matches no voice, so such loads are dropped.
  always_comb begin
    load_hit = '0;
    adv      = '0;
    done     = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      load_hit[v] = bus.load_new_note && (bus.voice_sel == VSEL_W'(v));
      adv[v]      = bus.generate_next_sample && bus.play_enable && (state_q[v] != IDLE);
      done[v]     = (state_q[v] != PLAYING);
    end
  end

  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      wave[v] = wave_of(phase_q[v], bus.wave_mode);
`ifdef NOTE_PLAYER_RELEASE_EN
      if (state_q[v] == RELEASE) wave[v] = wave[v] >>> rel_q[v];
`endif
    end
  end

  // Voice next-state: a load overrides both the beat decrement and the phase advance.
  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      state_d[v] = state_q[v];
      count_d[v] = count_q[v];
      phase_d[v] = phase_q[v];
      step_d[v]  = step_q[v];
`ifdef NOTE_PLAYER_RELEASE_EN
      rel_d[v]   = rel_q[v];
`endif
      if (adv[v]) phase_d[v] = phase_q[v] + step_q[v];
      if (load_hit[v]) begin
        count_d[v] = bus.duration_to_load;
        phase_d[v] = '0;
        step_d[v]  = bus.step_to_load;
        state_d[v] = (bus.duration_to_load != '0) ? PLAYING : IDLE;
`ifdef NOTE_PLAYER_RELEASE_EN
        rel_d[v]   = '0;
`endif
      end else if (beat_en) begin
        case (state_q[v])
          PLAYING: begin
            count_d[v] = count_q[v] - DUR_W'(1);
            if (count_q[v] == DUR_W'(1)) begin
`ifdef NOTE_PLAYER_RELEASE_EN
              state_d[v] = RELEASE;
              rel_d[v]   = 3'd1;
`else
              state_d[v] = IDLE;
`endif
            end
          end
`ifdef NOTE_PLAYER_RELEASE_EN
          RELEASE: begin
            if (rel_q[v] == 3'd4) begin
              state_d[v] = IDLE;
              rel_d[v]   = '0;
            end else begin
              rel_d[v]   = rel_q[v] + 3'd1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        state_q[v] <= IDLE;
        count_q[v] <= '0;
        phase_q[v] <= '0;
        step_q[v]  <= '0;
`ifdef NOTE_PLAYER_RELEASE_EN
        rel_q[v]   <= '0;
`endif
      end
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        state_q[v] <= state_d[v];
        count_q[v] <= count_d[v];
        phase_q[v] <= phase_d[v];
        step_q[v]  <= step_d[v];
`ifdef NOTE_PLAYER_RELEASE_EN
        rel_q[v]   <= rel_d[v];
`endif
      end
    end
  end

  // Three guard bits cover up to eight full-scale voices; saturate when they disagree with the sign.
  always_comb begin
    sum = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      sum = sum + {{3{s1_wave[v][SAMPLE_W-1]}}, s1_wave[v]};
    end
    if ((sum[SUM_W-1:SAMPLE_W-1] == '0) || (sum[SUM_W-1:SAMPLE_W-1] == '1)) begin
      mix = sum[SAMPLE_W-1:0];
    end else if (sum[SUM_W-1]) begin
      mix = SAT_MIN;
    end else begin
      mix = SAT_MAX;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld   <= 1'b0;
      sample_q <= '0;
      ready_q  <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) s1_wave[v] <= '0;
    end else begin
      s1_vld  <= bus.generate_next_sample;
      ready_q <= s1_vld;
      if (bus.generate_next_sample) begin
        for (int v = 0; v < NUM_VOICES; v++) s1_wave[v] <= adv[v] ? wave[v] : '0;
      end
      if (s1_vld) sample_q <= mix;
    end
  end

  assign bus.done_with_note   = done;
  assign bus.sample_out       = sample_q;
  assign bus.new_sample_ready = ready_q;
endmodule
